iccm_arbiter: RTL and testbench
===============================

// Module: iccm_arbiter
// PURPOSE
//  Shares the single-port instruction SRAM wrapper between the core fetch port (read-only) and
//  the program loader port (read/write). Sequences boot: only the loader may access memory until
//  boot completes; then the core is released and both ports are round-robin arbitrated.
//  Routes each read response back to the port that issued it. Sits between core/loader and the ICCM.
// PARAMETERS
//  AW  12  word address width (matches memory addr)
//  DW  32  data width; mask width is DW/8
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     asynchronous active-low reset
//  boot_done_i    in   1     loader pulse: program image fully written
//  reload_i       in   1     pulse: return to LOAD (core held again)
//  core_en_o      out  1     high in RUN; releases core fetch
//  core_req_i     in   1     core read request
//  core_addr_i    in   AW    core read address
//  core_gnt_o     out  1     core request accepted this cycle
//  core_rvalid_o  out  1     core read data valid
//  core_rdata_o   out  DW    core read data
//  ldr_req_i      in   1     loader request
//  ldr_we_i       in   1     loader write enable
//  ldr_addr_i     in   AW    loader address
//  ldr_wdata_i    in   DW    loader write data
//  ldr_wmask_i    in   DW/8  loader byte mask
//  ldr_gnt_o      out  1     loader request accepted this cycle
//  ldr_rvalid_o   out  1     loader read data valid
//  ldr_rdata_o    out  DW    loader read data
//  mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wmask_o  out  1/1/AW/DW/DW/8  to memory
//  mem_rdata_i    in   DW    memory read data
//  mem_rvalid_i   in   1     memory read valid (exactly 1 cycle after a read req; never for writes)
// BEHAVIOUR
//  - FSM {LOAD, RUN}. Reset -> LOAD. LOAD->RUN on boot_done_i; RUN->LOAD on reload_i
//    (reload_i wins if both high). core_en_o = (state==RUN), registered.
//  - LOAD: only loader granted; core_gnt_o=0 regardless of core_req_i.
//  - RUN: single requester -> granted. Both requesting -> grant the one NOT granted last
//    (last_grant flop, reset = CORE so loader wins first contention). last_grant updates only on grant.
//  - Grant is combinational, same cycle as req; no request is queued inside the block.
//    Requester must hold req/addr/data stable until gnt.
//  - mem_req_o = core_gnt_o | ldr_gnt_o (at most one gnt high). Mux addr/we/wdata/wmask from winner;
//    core path drives we=0, wmask=0, wdata=0. Idle: all mem_* outputs 0.
//  - rsp_owner flop {NONE, CORE, LDR}: set to winner on a read grant, NONE on write grant or idle.
//    x_rvalid_o = mem_rvalid_i & (rsp_owner==x); x_rdata_o = mem_rdata_i when owner==x, else 0.
//  - Read latency: 1 cycle req->rvalid; back-to-back reads from alternating ports fully pipelined.
//  - Write grant produces no rvalid on either port.
//  - State change (boot_done_i/reload_i) does not cancel a response already in flight;
//    it is still routed to its owner.
//  - Async reset mid-operation: state=LOAD, core_en_o=0, last_grant=CORE, rsp_owner=NONE;
//    any in-flight response is dropped (no rvalid on either port).
// TESTING
//  1. Reset, core_req_i=1 addr=0x010 in LOAD -> core_gnt_o=0, mem_req_o=0, core_en_o=0.
//  2. LOAD: loader write 0xDEADBEEF mask 0xF @0x004, then read @0x004
//     -> ldr_rvalid_o next cycle, ldr_rdata_o=0xDEADBEEF, core_rvalid_o=0.
//  3. boot_done_i pulse -> core_en_o=1 next cycle; core read @0x004 -> core_rdata_o=0xDEADBEEF 1 cycle later.
//  4. RUN, both req every cycle for 4 cycles -> grants LDR,CORE,LDR,CORE;
//     each rvalid on the issuing port only.
//  5. boot_done_i and reload_i same cycle in RUN -> stays LOAD path (state=LOAD), core_en_o=0.
//  6. Assert rst_ni low the cycle after a loader read grant -> ldr_rvalid_o=0, state LOAD.

Source files
------------

// File: rtl/iccm_arbiter_if.sv
// Bus bundle between the ICCM arbiter, its two requesters (core fetch, loader) and the SRAM wrapper.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface iccm_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic            core_req_i;
  logic [AW-1:0]   core_addr_i;
  logic            core_gnt_o;
  logic            core_rvalid_o;
  logic [DW-1:0]   core_rdata_o;

  logic            ldr_req_i;
  logic            ldr_we_i;
  logic [AW-1:0]   ldr_addr_i;
  logic [DW-1:0]   ldr_wdata_i;
  logic [DW/8-1:0] ldr_wmask_i;
  logic            ldr_gnt_o;
  logic            ldr_rvalid_o;
  logic [DW-1:0]   ldr_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_wmask_o;
  logic [DW-1:0]   mem_rdata_i;
  logic            mem_rvalid_i;

  modport slave (
    input  core_req_i, core_addr_i,
    input  ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i, ldr_wmask_i,
    input  mem_rdata_i, mem_rvalid_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );

  modport master (
    output core_req_i, core_addr_i,
    output ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i, ldr_wmask_i,
    output mem_rdata_i, mem_rvalid_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/iccm_arbiter.sv
// Boot-sequenced arbiter sharing the single-port ICCM between core fetch and program loader;
// loader-only in LOAD, round-robin in RUN, read responses steered back to the issuing port.
module iccm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic boot_done_i,
  input  logic reload_i,
  output logic core_en_o,
  output logic dbg_state_o,
  iccm_arbiter_if.slave bus
);
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CORE = 2'd1, OWN_LDR = 2'd2} owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   last_ldr_q, last_ldr_d;
  logic   core_gnt, ldr_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      owner_q    <= OWN_NONE;
      last_ldr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ldr_q <= last_ldr_d;
    end
  end

  // Handshake: a request is accepted in the cycle its gnt is high (combinational, same cycle);
  // the requester holds req/addr/data stable until then, and a read returns rvalid one cycle later.
  always_comb begin
    state_d    = state_q;
    owner_d    = OWN_NONE;
    last_ldr_d = last_ldr_q;
    core_gnt   = 1'b0;
    ldr_gnt    = 1'b0;

    if (reload_i) begin
      state_d = LOAD;
    end else if (boot_done_i) begin
      state_d = RUN;
    end

    // On contention the port that did not win last time gets the slot.
    if ((state_q == RUN) && bus.core_req_i) begin
      if (bus.ldr_req_i && !last_ldr_q) begin
        ldr_gnt = 1'b1;
      end else begin
        core_gnt = 1'b1;
      end
    end else if (bus.ldr_req_i) begin
      ldr_gnt = 1'b1;
    end

    if (core_gnt) begin
      last_ldr_d = 1'b0;
      owner_d    = OWN_CORE;
    end
    if (ldr_gnt) begin
      last_ldr_d = 1'b1;
      owner_d    = bus.ldr_we_i ? OWN_NONE : OWN_LDR;
    end
  end

  assign core_en_o   = (state_q == RUN);
  assign dbg_state_o = state_q;

  assign bus.core_gnt_o  = core_gnt;
  assign bus.ldr_gnt_o   = ldr_gnt;
  assign bus.mem_req_o   = core_gnt | ldr_gnt;
  assign bus.mem_we_o    = ldr_gnt & bus.ldr_we_i;
  assign bus.mem_addr_o  = ldr_gnt  ? bus.ldr_addr_i  :
                           core_gnt ? bus.core_addr_i : '0;
  assign bus.mem_wdata_o = ldr_gnt  ? bus.ldr_wdata_i : '0;
  assign bus.mem_wmask_o = ldr_gnt  ? bus.ldr_wmask_i : '0;

  assign bus.core_rvalid_o = bus.mem_rvalid_i & (owner_q == OWN_CORE);
  assign bus.ldr_rvalid_o  = bus.mem_rvalid_i & (owner_q == OWN_LDR);
  assign bus.core_rdata_o  = (owner_q == OWN_CORE) ? bus.mem_rdata_i : '0;
  assign bus.ldr_rdata_o   = (owner_q == OWN_LDR)  ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_iccm_arbiter.sv
// Self-checking bench for iccm_arbiter: directed boot/arbitration/reset scenarios then random
// traffic, checked against a behavioural memory/arbitration model and a response scoreboard.
module tb_iccm_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int EW = 1 + DW + 16;

  logic clk;
  logic rst_ni;
  logic boot_done;
  logic reload;
  logic core_en;
  logic dbg_state;

  iccm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  iccm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .boot_done_i (boot_done),
    .reload_i    (reload),
    .core_en_o   (core_en),
    .dbg_state_o (dbg_state),
    .bus         (bus)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // SRAM wrapper model: 1-cycle read latency, byte-masked writes
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    bus.mem_rvalid_i <= 1'b0;
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < DW/8; b++)
          if (bus.mem_wmask_o[b]) sram[bus.mem_addr_o][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rvalid_i <= 1'b1;
        bus.mem_rdata_i  <= sram[bus.mem_addr_o];
      end
    end
  end

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            model_run;
  bit            model_last_ldr;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  bit            c_req;
  logic [AW-1:0] c_addr;
  bit            l_req;
  bit            l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [3:0]    l_wmask;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every rvalid must match the oldest outstanding read, in the expected cycle
  logic [EW-1:0] mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.core_rvalid_o || bus.ldr_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {bus.core_rvalid_o, bus.ldr_rvalid_o}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("read_response",
                {bus.core_rvalid_o, bus.ldr_rvalid_o,
                 (bus.ldr_rvalid_o ? bus.ldr_rdata_o : bus.core_rdata_o),
                 (bus.ldr_rvalid_o ? bus.core_rdata_o : bus.ldr_rdata_o), cyc[15:0]},
                {~mon_e[EW-1], mon_e[EW-1], mon_e[EW-2:16], {DW{1'b0}}, mon_e[15:0]});
        end
      end else if (exp_q.size() > 0 && exp_q[0][15:0] == cyc[15:0]) begin
        mon_e = exp_q.pop_front();
        check("missing_rvalid", {bus.core_rvalid_o, bus.ldr_rvalid_o}, {~mon_e[EW-1], mon_e[EW-1]});
      end
    end
  end

  // driver: present pending requests for one cycle, check grants/mem bus, update the model
  task automatic step(input bit boot, input bit rel);
    bit exp_cg, exp_lg;
    logic [AW+DW+5:0] exp_mem;
    @(negedge clk);
    boot_done       = boot;
    reload          = rel;
    bus.core_req_i  = c_req;
    bus.core_addr_i = c_addr;
    bus.ldr_req_i   = l_req;
    bus.ldr_we_i    = l_we;
    bus.ldr_addr_i  = l_addr;
    bus.ldr_wdata_i = l_wdata;
    bus.ldr_wmask_i = l_wmask;
    #1;
    exp_cg = model_run && c_req && !(l_req && !model_last_ldr);
    exp_lg = l_req && !exp_cg;
    if (exp_lg)      exp_mem = {1'b1, l_we, l_addr, l_wdata, l_wmask};
    else if (exp_cg) exp_mem = {1'b1, 1'b0, c_addr, {DW{1'b0}}, 4'h0};
    else             exp_mem = '0;
    check("core_en", core_en, model_run);
    check("dbg_state", dbg_state, model_run);
    check("grants", {bus.core_gnt_o, bus.ldr_gnt_o}, {exp_cg, exp_lg});
    check("mem_bus", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o},
          exp_mem);
    if (exp_lg) begin
      if (l_we) begin
        for (int b = 0; b < 4; b++)
          if (l_wmask[b]) ref_mem[l_addr][8*b +: 8] = l_wdata[8*b +: 8];
      end else begin
        exp_q.push_back({1'b1, ref_mem[l_addr], 16'(cyc + 1)});
      end
      model_last_ldr = 1'b1;
      l_req = 1'b0;
    end
    if (exp_cg) begin
      exp_q.push_back({1'b0, ref_mem[c_addr], 16'(cyc + 1)});
      model_last_ldr = 1'b0;
      c_req = 1'b0;
    end
    if (rel)       model_run = 1'b0;
    else if (boot) model_run = 1'b1;
  endtask

  // asynchronous reset asserted just after a clock edge, released at the next falling edge
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_ni         = 1'b0;
    boot_done      = 1'b0;
    reload         = 1'b0;
    bus.core_req_i = 1'b0;
    bus.ldr_req_i  = 1'b0;
    exp_q.delete();
    model_run      = 1'b0;
    model_last_ldr = 1'b0;
    #1;
    check("rst_core_en", core_en, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    check("rst_rvalid", {bus.core_rvalid_o, bus.ldr_rvalid_o}, 2'b00);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic ldr_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] m);
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d; l_wmask = m;
  endtask

  initial begin
    rst_ni = 1'b0; boot_done = 1'b0; reload = 1'b0;
    bus.core_req_i = 1'b0; bus.core_addr_i = '0;
    bus.ldr_req_i = 1'b0; bus.ldr_we_i = 1'b0; bus.ldr_addr_i = '0;
    bus.ldr_wdata_i = '0; bus.ldr_wmask_i = '0;
    c_req = 0; c_addr = '0; l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0; l_wmask = '0;
    model_run = 0; model_last_ldr = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // core request while loading is ignored
    c_req = 1; c_addr = 12'h010;
    step(0, 0);
    c_req = 0;

    // loader write then read back in LOAD
    ldr_op(1, 12'h004, 32'hDEADBEEF, 4'hF);
    step(0, 0);
    ldr_op(0, 12'h004, 32'h0, 4'h0);
    step(0, 0);
    step(0, 0);

    // boot, then core reads the loaded word
    step(1, 0);
    c_req = 1; c_addr = 12'h004;
    step(0, 0);
    step(0, 0);

    // contention every cycle for four cycles
    for (int i = 0; i < 4; i++) begin
      c_req = 1; c_addr = AW'(i);
      ldr_op(0, AW'(i + 8), 32'h0, 4'h0);
      step(0, 0);
    end
    step(0, 0);

    // reload wins over boot_done
    step(1, 1);
    step(0, 0);
    step(0, 0);

    // reset the cycle after a loader read grant drops the response
    ldr_op(0, 12'h004, 32'h0, 4'h0);
    step(0, 0);
    apply_reset();
    step(0, 0);
    step(1, 0);

    // randomized traffic with occasional boot/reload pulses and in-flight resets
    for (int i = 0; i < 400; i++) begin
      if (!c_req && $urandom_range(0, 2) != 0) begin
        c_req = 1; c_addr = AW'($urandom_range(0, 63));
      end
      if (!l_req && $urandom_range(0, 2) != 0)
        ldr_op($urandom_range(0, 1), AW'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      if (i % 97 == 96) apply_reset();
    end

    c_req = 0; l_req = 0;
    repeat (3) step(0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
